bit_serializer: RTL and testbench

//   Parallel-to-serial stage directly upstream of the serial pattern detector.
//   - Accepts WIDTH-bit words over a valid/ready handshake.
//   - Shifts each word out one bit per clk on ser_bit; ser_bit drives the detector's x input.
//   - A one-entry hold buffer lets consecutive words stream with no idle gap.

---
 rtl/ser_pkg.sv | 7 +
 rtl/ser_hold_buf.sv | 24 ++
 rtl/bit_serializer.sv | 96 +++++++++
 tb/tb_bit_serializer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// ser_pkg: shared FSM state type and counter-width helper for bit_serializer.
package ser_pkg;
    typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;
    function automatic int ser_cnt_w(input int frame);
        return $clog2(frame + 1);
    endfunction
endpackage

// File: rtl/ser_hold_buf.sv
// ser_hold_buf: one-entry word register with full flag; load fills it, pop empties it.
module ser_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);
    logic [WIDTH-1:0] data_q;
    logic             full_q, full_d;
    assign full_d   = load | (full_q & ~pop);
    assign out_data = data_q;
    assign full     = full_q;
    always_ff @(posedge clk) begin
        full_q <= rst ? 1'b0 : full_d;
    end
    always_ff @(posedge clk) begin
        if (load) data_q <= in_data;
    end
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial stage with one-entry hold buffer for gapless streaming.
// Define SER_PARITY_EN to append an even-parity bit after the data bits of every frame.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);
`ifdef SER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = ser_cnt_w(FRAME);
    ser_state_t       state_q, state_d;
    logic [FRAME-1:0] sr_q, sr_d, frame_w;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_q, bit_d, last_q, last_d;
    logic [WIDTH-1:0] hold_data, src, ord;
    logic             hold_full, hold_load, hold_pop, xfer, load;
    assign in_ready  = !hold_full;
    assign xfer      = in_valid && in_ready;
    assign busy      = (state_q == SER_SHIFT) | hold_full;
    assign ser_valid = state_q == SER_SHIFT;
    assign ser_bit   = bit_q;
    assign ser_last  = last_q;
    // A full hold buffer always wins the next shifter load; otherwise the input word is taken.
    assign src = hold_full ? hold_data : in_data;
    always_comb begin
        for (int i = 0; i < WIDTH; i++) ord[i] = (MSB_FIRST != 0) ? src[i] : src[WIDTH-1-i];
    end
`ifdef SER_PARITY_EN
    assign frame_w = {ord, ^src};
`else
    assign frame_w = ord;
`endif
    ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (hold_load),
        .in_data (in_data),
        .pop     (hold_pop),
        .out_data(hold_data),
        .full    (hold_full)
    );
    always_comb begin
        state_d   = state_q;
        sr_d      = {sr_q[FRAME-2:0], 1'b0};
        cnt_d     = cnt_q + 1'b1;
        hold_load = 1'b0;
        hold_pop  = 1'b0;
        load      = 1'b0;
        if (state_q == SER_IDLE) begin
            load = xfer;
        end else if (last_q) begin
            load     = hold_full | xfer;
            hold_pop = hold_full;
            state_d  = SER_IDLE;
        end else begin
            hold_load = xfer;
        end
        if (load) begin
            sr_d    = frame_w;
            cnt_d   = '0;
            state_d = SER_SHIFT;
        end
        bit_d  = (state_d == SER_SHIFT) ? sr_d[FRAME-1] : IDLE_LEVEL;
        last_d = (state_d == SER_SHIFT) && (cnt_d == CW'(FRAME - 1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bit_q   <= IDLE_LEVEL;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: scoreboard bench driving an MSB-first and an LSB-first instance in lockstep.
module tb_bit_serializer;
    localparam int W = 4;
`ifdef SER_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif
    typedef struct packed {logic b; logic l;} exp_t;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic a_ready, a_bit, a_valid, a_last, a_busy;
    logic b_ready, b_bit, b_valid, b_last, b_busy;
    int n_vec = 0, n_err = 0;
    exp_t q_a[$], q_b[$];
    exp_t ea, eb;
    logic acc_s = 1'b0, rst_s = 1'b1;
    logic [W-1:0] w_s = '0;
    always #5 clk = ~clk;
    bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_ready),
        .ser_bit(a_bit), .ser_valid(a_valid), .ser_last(a_last), .busy(a_busy)
    );
    bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_ready),
        .ser_bit(b_bit), .ser_valid(b_valid), .ser_last(b_last), .busy(b_busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic fbit(input logic [W-1:0] w, input int i, input bit msb);
        if (i >= W) return ^w;
        return msb ? w[W-1-i] : w[i];
    endfunction
    always @(negedge clk) begin
        if (!rst) begin
            if (a_valid) begin
                if (q_a.size() == 0) check("a_extra_bit", 1, 0);
                else begin
                    ea = q_a.pop_front();
                    check("a_bit", {a_bit, a_last}, {ea.b, ea.l});
                end
            end else begin
                check("a_idle", {a_bit, a_last}, 0);
                check("a_gap", q_a.size(), 0);
            end
            if (b_valid) begin
                if (q_b.size() == 0) check("b_extra_bit", 1, 0);
                else begin
                    eb = q_b.pop_front();
                    check("b_bit", {b_bit, b_last}, {eb.b, eb.l});
                end
            end else begin
                check("b_idle", {b_bit, b_last}, 0);
                check("b_gap", q_b.size(), 0);
            end
        end
        acc_s = in_valid && a_ready && !rst;
        rst_s = rst;
        w_s   = in_data;
    end
    always @(posedge clk) begin
        if (rst_s) begin
            q_a.delete();
            q_b.delete();
        end else if (acc_s) begin
            for (int i = 0; i < FRAME; i++) begin
                q_a.push_back({fbit(w_s, i, 1'b1), i == FRAME - 1});
                q_b.push_back({fbit(w_s, i, 1'b0), i == FRAME - 1});
            end
        end
    end
    task automatic send(input logic [W-1:0] w);
        int t = 0;
        in_data  = w;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!a_ready && t < 50);
        if (!a_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask
    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic drain();
        int t = 0;
        while ((q_a.size() != 0 || q_b.size() != 0 || a_busy || b_busy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", t < 100, 1);
        @(negedge clk);
        check("drained_idle", {a_busy, b_busy, a_valid, b_valid, a_ready, b_ready}, 6'b000011);
        @(posedge clk);
        #1;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {a_valid, b_valid}, 0);
        check("rst_bit", {a_bit, b_bit}, 0);
        check("rst_last", {a_last, b_last}, 0);
        check("rst_ready", {a_ready, b_ready}, 2'b11);
        check("rst_busy", {a_busy, b_busy}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        gap(2);
        send(4'b1010);
        drain();
        send(4'b0101);
        gap(1);
        send(4'b1100);
        for (int i = 0; i < FRAME - 2; i++) begin
            @(negedge clk);
            check("t2_ready_low", a_ready, 0);
        end
        @(negedge clk);
        check("t2_ready_back", a_ready, 1);
        drain();
        send(4'b0001);
        drain();
        send(4'b1111);
        send(4'b1111);
        check("t4_hold_full", {a_ready, a_busy}, 2'b01);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t4_valid", a_valid, 0);
        check("t4_bit", a_bit, 0);
        check("t4_ready", a_ready, 1);
        check("t4_busy", a_busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        gap(8);
        send(4'b1011);
        drain();
        send(4'b1001);
        send(4'b0110);
        in_data  = 4'b1110;
        in_valid = 1'b1;
        @(negedge clk);
        check("t6_ready_low", a_ready, 0);
        send(4'b1110);
        drain();
        repeat (12) begin
            send(W'($urandom_range(0, (1 << W) - 1)));
            gap($urandom_range(0, 3));
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
